// File: rtl/vga_pkg.sv
// Shared state, mode types and helpers for the raster timing generator.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } vga_state_t;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
  } vga_mode_t;

  localparam vga_mode_t VGA_640x480 = '{
    h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
  };

  function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_clk_div.sv
// Pixel clock-enable and divided DAC clock; pixel_clk falls on the edge that ends
// each pixel_ce cycle so downstream outputs are stable at its rising edge.
module vga_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic Clk,
  input  logic Reset,
  output logic pixel_ce,
  output logic pixel_clk
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DC_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DC_HALF = DW'(CLK_DIV / 2);

  logic [DW-1:0] dc_q, dc_d;
  logic          pixel_ce_q, pixel_clk_q;

  always_comb begin
    dc_d = (dc_q == DC_LAST) ? '0 : dc_q + DW'(1);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dc_q        <= '0;
      pixel_ce_q  <= 1'b0;
      pixel_clk_q <= 1'b0;
    end else begin
      dc_q        <= dc_d;
      pixel_ce_q  <= (dc_q == DC_LAST);
      pixel_clk_q <= (dc_q >= DC_HALF);
    end
  end

  assign pixel_ce  = pixel_ce_q;
  assign pixel_clk = pixel_clk_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with an enable handshake that starts scan-out
// on request and only stops at a frame boundary.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_640x480.h_active,
  parameter int H_FP     = VGA_640x480.h_fp,
  parameter int H_SYNC   = VGA_640x480.h_sync,
  parameter int H_BP     = VGA_640x480.h_bp,
  parameter int V_ACTIVE = VGA_640x480.v_active,
  parameter int V_FP     = VGA_640x480.v_fp,
  parameter int V_SYNC   = VGA_640x480.v_sync,
  parameter int V_BP     = VGA_640x480.v_bp,
  parameter int CLK_DIV  = 2,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Enable,
  output logic          pixel_ce,
  output logic          pixel_clk,
  output logic          hs,
  output logic          vs,
  output logic          blank_n,
  output logic          sync_n,
  output logic [CW-1:0] DrawX,
  output logic [CW-1:0] DrawY,
  output logic          line_start,
  output logic          frame_start,
  output logic          running
);

  localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_STOP  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_STOP  = CW'(V_ACTIVE + V_FP + V_SYNC);

  vga_state_t    state_q, state_d;
  logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;
  logic [CW-1:0] hcAdv, vcAdv;
  logic          endOfFrame, runNext;
  logic          hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic          line_start_q, line_start_d, frame_start_q, frame_start_d;

  vga_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .Clk      (Clk),
    .Reset    (Reset),
    .pixel_ce (pixel_ce),
    .pixel_clk(pixel_clk)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      hc_q    <= '0;
      vc_q    <= '0;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      vc_q    <= vc_d;
    end
  end

  // Enable rising exactly at end of frame while draining resumes RUN with a normal wrap.
  always_comb begin
    endOfFrame = (hc_q == H_LAST) && (vc_q == V_LAST);
    hcAdv      = (hc_q == H_LAST) ? '0 : hc_q + CW'(1);
    vcAdv      = vc_q;
    if (hc_q == H_LAST) begin
      vcAdv = (vc_q == V_LAST) ? '0 : vc_q + CW'(1);
    end
    state_d = state_q;
    hc_d    = hc_q;
    vc_d    = vc_q;
    if (pixel_ce) begin
      case (state_q)
        IDLE: begin
          hc_d = '0;
          vc_d = '0;
          if (Enable) state_d = RUN;
        end
        RUN: begin
          hc_d = hcAdv;
          vc_d = vcAdv;
          if (!Enable) state_d = DRAIN;
        end
        DRAIN: begin
          hc_d = hcAdv;
          vc_d = vcAdv;
          if (Enable) state_d = RUN;
          else if (endOfFrame) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          hc_d    = '0;
          vc_d    = '0;
        end
      endcase
    end
  end

  always_comb begin
    runNext       = (state_d != IDLE);
    hs_d          = (runNext && hc_d >= HS_START && hc_d < HS_STOP) ? HS_POL : ~HS_POL;
    vs_d          = (runNext && vc_d >= VS_START && vc_d < VS_STOP) ? VS_POL : ~VS_POL;
    blank_n_d     = runNext && (hc_d < H_VIS) && (vc_d < V_VIS);
    line_start_d  = runNext && (hc_d == '0);
    frame_start_d = runNext && (hc_d == '0) && (vc_d == '0);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      blank_n_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (pixel_ce) begin
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank_n     = blank_n_q;
  assign sync_n      = 1'b0;
  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign running     = (state_q != IDLE);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 instance plus a tiny mode instance.
module tb_vga_timing_gen;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Enable = 1'b0;
  logic       EnableS = 1'b0;

  logic       pixelCe, pixelClk, hs, vs, blankN, syncN, lineStart, frameStart, running;
  logic [9:0] drawX, drawY;
  logic       pixelCeS, pixelClkS, hsS, vsS, blankNS, syncNS, lineStartS, frameStartS, runningS;
  logic [3:0] drawXS, drawYS;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cycleCount++;

  vga_timing_gen dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable),
    .pixel_ce(pixelCe), .pixel_clk(pixelClk), .hs(hs), .vs(vs),
    .blank_n(blankN), .sync_n(syncN), .DrawX(drawX), .DrawY(drawY),
    .line_start(lineStart), .frame_start(frameStart), .running(running)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(4), .HS_POL(1'b1), .VS_POL(1'b1), .CW(4)
  ) dutS (
    .Clk(Clk), .Reset(Reset), .Enable(EnableS),
    .pixel_ce(pixelCeS), .pixel_clk(pixelClkS), .hs(hsS), .vs(vsS),
    .blank_n(blankNS), .sync_n(syncNS), .DrawX(drawXS), .DrawY(drawYS),
    .line_start(lineStartS), .frame_start(frameStartS), .running(runningS)
  );

  task automatic waitPce();
    int n = 0;
    do begin @(negedge Clk); n++; end while (pixelCe !== 1'b1 && n < 16);
    if (pixelCe !== 1'b1) begin
      checks++; errors++;
      $display("[TB] FAIL pce_timeout: pixel_ce=%b required 1", pixelCe);
    end
  endtask

  task automatic waitPceS();
    int n = 0;
    do begin @(negedge Clk); n++; end while (pixelCeS !== 1'b1 && n < 16);
    if (pixelCeS !== 1'b1) begin
      checks++; errors++;
      $display("[TB] FAIL pce_s_timeout: pixel_ce=%b required 1", pixelCeS);
    end
  endtask

  task automatic test_reset();
    logic [3:0] ceSeq, ceSeqS, clkSeqS;
    Reset = 1'b1; Enable = 1'b0; EnableS = 1'b0;
    repeat (3) @(negedge Clk);
    checks++;
    if ({pixelCe, pixelClk, hs, vs, blankN, syncN, lineStart, frameStart, running} !== 9'b0_0_1_1_0_0_0_0_0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b required %b",
               {pixelCe, pixelClk, hs, vs, blankN, syncN, lineStart, frameStart, running}, 9'b001100000);
    end
    checks++;
    if (drawX !== 10'd0 || drawY !== 10'd0) begin
      errors++; $display("[TB] FAIL reset_xy: got (%0d,%0d) required (0,0)", drawX, drawY);
    end
    checks++;
    if ({pixelCeS, pixelClkS, hsS, vsS, blankNS, syncNS, lineStartS, frameStartS, runningS} !== 9'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags_small: got %b required %b",
               {pixelCeS, pixelClkS, hsS, vsS, blankNS, syncNS, lineStartS, frameStartS, runningS}, 9'b0);
    end
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      ceSeq[i]   = pixelCe;
      ceSeqS[i]  = pixelCeS;
      clkSeqS[i] = pixelClkS;
    end
    checks++;
    if (ceSeq !== 4'b1010) begin
      errors++; $display("[TB] FAIL first_pce: got %b required %b", ceSeq, 4'b1010);
    end
    checks++;
    if (ceSeqS !== 4'b1000) begin
      errors++; $display("[TB] FAIL first_pce_small: got %b required %b", ceSeqS, 4'b1000);
    end
    checks++;
    if (clkSeqS !== 4'b1100) begin
      errors++; $display("[TB] FAIL pixel_clk_start_small: got %b required %b", clkSeqS, 4'b1100);
    end
  endtask

  task automatic test_idle_enable();
    int  bad = 0;
    bit  found = 0;
    repeat (1000) begin
      @(negedge Clk);
      if ({hs, vs, blankN, running, frameStart} !== 5'b11000 || drawX !== 10'd0 || drawY !== 10'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL idle_outputs: %0d bad cycles, required 0", bad);
    end
    Enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      if (frameStart === 1'b1) begin found = 1; break; end
    end
    checks++;
    if (!found) begin
      errors++; $display("[TB] FAIL enable_latency: frame_start=%b required 1 within 2 Clk", frameStart);
    end
    checks++;
    if (drawX !== 10'd0 || drawY !== 10'd0 || running !== 1'b1 || blankN !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_pixel: got (%0d,%0d) running=%b blank_n=%b required (0,0) 1 1",
               drawX, drawY, running, blankN);
    end
  endtask

  task automatic test_line_timing();
    int x, y;
    int posBad = 0, hsBad = 0, blankBad = 0, lsBad = 0, fsBad = 0, vsBad = 0;
    int hsLow[2], firstLow[2], lineTime[2];
    hsLow = '{0, 0}; firstLow = '{-1, -1}; lineTime = '{0, 0};
    waitPce();
    for (int i = 0; i < 1600; i++) begin
      if (i > 0) waitPce();
      x = i % 800;
      y = i / 800;
      if (drawX !== 10'(x) || drawY !== 10'(y)) posBad++;
      if (hs !== ((x >= 656 && x < 752) ? 1'b0 : 1'b1)) hsBad++;
      if (hs === 1'b0) begin
        hsLow[y]++;
        if (firstLow[y] < 0) firstLow[y] = int'(drawX);
      end
      if (blankN !== (x < 640)) blankBad++;
      if (lineStart !== (x == 0)) lsBad++;
      if (frameStart !== (i == 0)) fsBad++;
      if (vs !== 1'b1) vsBad++;
      if (x == 0) lineTime[y] = cycleCount;
    end
    checks++; if (posBad != 0)   begin errors++; $display("[TB] FAIL scan_position: %0d bad pixels, required 0", posBad); end
    checks++; if (hsBad != 0)    begin errors++; $display("[TB] FAIL hs_window: %0d bad pixels, required 0", hsBad); end
    checks++; if (hsLow[0] != 96 || hsLow[1] != 96) begin
      errors++; $display("[TB] FAIL hs_width: got %0d/%0d required 96/96", hsLow[0], hsLow[1]);
    end
    checks++; if (firstLow[0] != 656) begin errors++; $display("[TB] FAIL hs_start: got %0d required 656", firstLow[0]); end
    checks++; if (blankBad != 0) begin errors++; $display("[TB] FAIL blank_n: %0d bad pixels, required 0", blankBad); end
    checks++; if (lsBad != 0)    begin errors++; $display("[TB] FAIL line_start: %0d bad pixels, required 0", lsBad); end
    checks++; if (fsBad != 0)    begin errors++; $display("[TB] FAIL frame_start: %0d bad pixels, required 0", fsBad); end
    checks++; if (vsBad != 0)    begin errors++; $display("[TB] FAIL vs_idle_lines: %0d bad pixels, required 0", vsBad); end
    checks++; if (lineTime[1] - lineTime[0] != 1600) begin
      errors++; $display("[TB] FAIL line_period: got %0d required 1600", lineTime[1] - lineTime[0]);
    end
  endtask

  task automatic test_reset_midframe();
    int  n = 0;
    bit  found = 0;
    while (!(drawX === 10'd320 && drawY === 10'd2) && n < 400) begin waitPce(); n++; end
    checks++;
    if (drawX !== 10'd320 || drawY !== 10'd2) begin
      errors++; $display("[TB] FAIL reach_320_2: got (%0d,%0d) required (320,2)", drawX, drawY);
    end
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({pixelCe, pixelClk, hs, vs, blankN, lineStart, frameStart, running} !== 8'b0011_0000 ||
        drawX !== 10'd0 || drawY !== 10'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: flags %b (%0d,%0d) required %b (0,0)",
               {pixelCe, pixelClk, hs, vs, blankN, lineStart, frameStart, running}, drawX, drawY, 8'b00110000);
    end
    @(negedge Clk);
    Reset = 1'b0;
    n = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge Clk);
      if (frameStart === 1'b1) begin found = 1; n = i; break; end
    end
    checks++;
    if (!found || n != 3) begin
      errors++; $display("[TB] FAIL restart_latency: frame_start at Clk %0d required 3", n);
    end
    waitPce();
    checks++;
    if (drawX !== 10'd0 || drawY !== 10'd0) begin
      errors++; $display("[TB] FAIL restart_origin: got (%0d,%0d) required (0,0)", drawX, drawY);
    end
    waitPce();
    checks++;
    if (drawX !== 10'd1 || drawY !== 10'd0) begin
      errors++; $display("[TB] FAIL restart_advance: got (%0d,%0d) required (1,0)", drawX, drawY);
    end
  endtask

  task automatic test_small_mode();
    int  x, y, n = 0;
    int  posBad = 0, hsBad = 0, vsBad = 0, blankBad = 0, ceClkBad = 0;
    int  frameTime[2];
    logic [3:0] clkSeq, ceSeq;
    frameTime = '{0, 0};
    EnableS = 1'b1;
    while (frameStartS !== 1'b1 && n < 8) begin @(negedge Clk); n++; end
    checks++;
    if (frameStartS !== 1'b1 || n > 4) begin
      errors++; $display("[TB] FAIL small_enable_latency: got %0d Clk required <= 4", n);
    end
    waitPceS();
    for (int i = 0; i < 196; i++) begin
      if (i > 0) waitPceS();
      x = i % 14;
      y = (i / 14) % 7;
      if (drawXS !== 4'(x) || drawYS !== 4'(y) || frameStartS !== (x == 0 && y == 0)) posBad++;
      if (hsS !== (x == 10 || x == 11)) hsBad++;
      if (vsS !== (y == 5)) vsBad++;
      if (blankNS !== (x < 8 && y < 4)) blankBad++;
      if (pixelClkS !== 1'b1) ceClkBad++;
      if (x == 0 && y == 0) frameTime[i / 98] = cycleCount;
    end
    checks++; if (posBad != 0)   begin errors++; $display("[TB] FAIL small_scan: %0d bad pixels, required 0", posBad); end
    checks++; if (hsBad != 0)    begin errors++; $display("[TB] FAIL small_hs: %0d bad pixels, required 0", hsBad); end
    checks++; if (vsBad != 0)    begin errors++; $display("[TB] FAIL small_vs: %0d bad pixels, required 0", vsBad); end
    checks++; if (blankBad != 0) begin errors++; $display("[TB] FAIL small_blank_n: %0d bad pixels, required 0", blankBad); end
    checks++; if (ceClkBad != 0) begin errors++; $display("[TB] FAIL small_pclk_at_ce: %0d bad, required 0", ceClkBad); end
    checks++;
    if (frameTime[1] - frameTime[0] != 392) begin
      errors++; $display("[TB] FAIL small_frame_period: got %0d required 392", frameTime[1] - frameTime[0]);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      clkSeq[i] = pixelClkS;
      ceSeq[i]  = pixelCeS;
    end
    checks++;
    if (clkSeq !== 4'b1100 || ceSeq !== 4'b1000) begin
      errors++; $display("[TB] FAIL small_pixel_clk: clk %b ce %b required 1100 1000", clkSeq, ceSeq);
    end
  endtask

  task automatic test_drain();
    int  x, y, idx, n = 0;
    int  posBad = 0, runBad = 0, parkBad = 0;
    while (!(drawXS === 4'd3 && drawYS === 4'd1) && n < 40) begin waitPceS(); n++; end
    checks++;
    if (drawXS !== 4'd3 || drawYS !== 4'd1) begin
      errors++; $display("[TB] FAIL reach_3_1: got (%0d,%0d) required (3,1)", drawXS, drawYS);
    end
    EnableS = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      waitPceS();
      idx = 17 + k;
      x = idx % 14;
      y = idx / 14;
      if (drawXS !== 4'(x) || drawYS !== 4'(y) || blankNS !== (x < 8 && y < 4)) posBad++;
      if (runningS !== 1'b1) runBad++;
    end
    checks++; if (posBad != 0) begin errors++; $display("[TB] FAIL drain_scan: %0d bad pixels, required 0", posBad); end
    checks++; if (runBad != 0) begin errors++; $display("[TB] FAIL drain_running: %0d bad pixels, required 0", runBad); end
    waitPceS();
    checks++;
    if ({runningS, blankNS, hsS, vsS, frameStartS, lineStartS} !== 6'b0 || drawXS !== 4'd0 || drawYS !== 4'd0) begin
      errors++;
      $display("[TB] FAIL drain_park: flags %b (%0d,%0d) required 000000 (0,0)",
               {runningS, blankNS, hsS, vsS, frameStartS, lineStartS}, drawXS, drawYS);
    end
    repeat (20) begin
      waitPceS();
      if (runningS !== 1'b0 || drawXS !== 4'd0 || drawYS !== 4'd0) parkBad++;
    end
    checks++; if (parkBad != 0) begin errors++; $display("[TB] FAIL park_hold: %0d bad pixels, required 0", parkBad); end
  endtask

  task automatic test_reraise();
    int  p, n = 0;
    int  posBad = 0, runBad = 0;
    EnableS = 1'b1;
    while (frameStartS !== 1'b1 && n < 8) begin @(negedge Clk); n++; end
    waitPceS();
    checks++;
    if (drawXS !== 4'd0 || drawYS !== 4'd0 || frameStartS !== 1'b1) begin
      errors++; $display("[TB] FAIL reraise_start: got (%0d,%0d) fs=%b required (0,0) 1", drawXS, drawYS, frameStartS);
    end
    for (int idx = 1; idx <= 99; idx++) begin
      waitPceS();
      p = idx % 98;
      if (drawXS !== 4'(p % 14) || drawYS !== 4'(p / 14) || frameStartS !== (p == 0)) posBad++;
      if (runningS !== 1'b1) runBad++;
      if (idx == 19) EnableS = 1'b0;
      if (idx == 47) EnableS = 1'b1;
    end
    checks++; if (posBad != 0) begin errors++; $display("[TB] FAIL reraise_scan: %0d bad pixels, required 0", posBad); end
    checks++; if (runBad != 0) begin errors++; $display("[TB] FAIL reraise_running: %0d bad pixels, required 0", runBad); end
  endtask

  task automatic test_back_to_back();
    int  p;
    int  posBad = 0, runBad = 0;
    for (int idx = 100; idx <= 197; idx++) begin
      waitPceS();
      p = idx % 98;
      if (drawXS !== 4'(p % 14) || drawYS !== 4'(p / 14)) posBad++;
      if (runningS !== 1'b1) runBad++;
      if (idx == 126) EnableS = 1'b0;
      if (idx == 195) EnableS = 1'b1;
    end
    checks++; if (posBad != 0) begin errors++; $display("[TB] FAIL eof_rise_scan: %0d bad pixels, required 0", posBad); end
    checks++; if (runBad != 0) begin errors++; $display("[TB] FAIL eof_rise_running: %0d bad pixels, required 0", runBad); end
    checks++;
    if (drawXS !== 4'd1 || drawYS !== 4'd0 || runningS !== 1'b1) begin
      errors++; $display("[TB] FAIL eof_rise_resume: got (%0d,%0d) running=%b required (1,0) 1", drawXS, drawYS, runningS);
    end
  endtask

  initial begin
    test_reset();
    test_idle_enable();
    test_line_timing();
    test_reset_midframe();
    test_small_mode();
    test_drain();
    test_reraise();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
